// File: rtl/retire_free_list.sv
// Commit-side retirement RAT and physical-register free list.
// Commits recycle the displaced mapping; flush rewinds the speculative head to the retired head.
module retire_free_list #(
  parameter int NUM_REGS  = 64,
  parameter int ARCH_REGS = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               commit_valid,
  input  logic [4:0]                         commit_arch_rd,
  input  logic [$clog2(NUM_REGS)-1:0]        commit_phys_rd,
  input  logic                               flush,
  input  logic                               alloc_req,
  output logic [$clog2(NUM_REGS)-1:0]        alloc_phys,
  output logic                               alloc_ok,
  output logic [$clog2(NUM_REGS)-1:0]        free_count,
  output logic [32*$clog2(NUM_REGS)-1:0]     rrat_flat
);

  localparam int W     = $clog2(NUM_REGS);
  localparam int DEPTH = NUM_REGS - 32;
  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = IW + 1;

  // Handshake: rename sees alloc_phys/alloc_ok combinationally; a pop happens
  // on the edge where alloc_req && alloc_ok, otherwise alloc_req is ignored.

  logic [W-1:0]  rrat [ARCH_REGS];
  logic [W-1:0]  fifo [DEPTH];
  logic [PW-1:0] tail;
  logic [PW-1:0] spec_head;
  logic [PW-1:0] arch_head;

  logic          do_commit;
  logic          do_pop;
  logic [W-1:0]  old_phys;
  logic [PW-1:0] arch_head_nxt;
  logic [PW-1:0] fill;

  assign do_commit     = commit_valid && (commit_arch_rd != 5'd0);
  assign old_phys      = rrat[commit_arch_rd];
  assign arch_head_nxt = do_commit ? arch_head + PW'(1) : arch_head;

  assign alloc_ok   = (tail != spec_head) && !flush;
  assign do_pop     = alloc_req && alloc_ok;
  assign alloc_phys = fifo[spec_head[IW-1:0]];
  assign fill       = tail - spec_head;
  assign free_count = W'(fill);

  for (genvar i = 0; i < 32; i++) begin : g_flat
    assign rrat_flat[i*W +: W] = rrat[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rrat[i] <= W'(i);
      for (int k = 0; k < DEPTH; k++) fifo[k] <= W'(32 + k);
      tail      <= PW'(DEPTH);
      spec_head <= '0;
      arch_head <= '0;
    end else begin
      if (do_commit) begin
        rrat[commit_arch_rd]  <= commit_phys_rd;
        fifo[tail[IW-1:0]]    <= old_phys;
        tail                  <= tail + PW'(1);
      end
      arch_head <= arch_head_nxt;
      // Flush sees the same-cycle commit's retired head; pops are blocked by alloc_ok.
      if (flush)       spec_head <= arch_head_nxt;
      else if (do_pop) spec_head <= spec_head + PW'(1);
    end
  end

endmodule
